// File: rtl/midi_tx.sv
// MIDI Channel Voice encoder: turns note-on/off requests into status/note/velocity bytes on a valid/ready stream.
// Optional running status is enabled by defining MIDI_RUNNING_STATUS_EN.
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module midi_tx #(
    parameter logic [3:0] MIDI_CHANNEL    = 4'd0,
    parameter logic [6:0] DEFAULT_OFF_VEL = 7'd64
) (
    input  logic                          clk_i,
    input  logic                          nrst_i,
    input  logic                          noteOnStrb_i,
    input  logic                          noteOffStrb_i,
    input  logic [`MIDI_PAYLOAD_BITS-1:0] note_i,
    input  logic [`MIDI_PAYLOAD_BITS-1:0] vel_i,
    output logic                          busy_o,
    output logic [7:0]                    midiByte_o,
    output logic                          midiByteValid_o,
    input  logic                          midiByteReady_i,
    output logic                          dropStrb_o
);

    typedef enum logic [1:0] {IDLE, STATUS, NOTE, VEL} state_t;

    state_t     r_state;
    logic [7:0] r_note;
    logic [7:0] r_vel;
    logic [7:0] r_byte;
    logic       r_valid;
    logic       r_busy;
    logic       r_drop;
`ifdef MIDI_RUNNING_STATUS_EN
    logic [7:0] r_lastStatus;
`endif

    logic       w_req;
    logic       w_hs;
    logic [7:0] w_status;

    assign w_req    = noteOnStrb_i | noteOffStrb_i;
    assign w_hs     = r_valid & midiByteReady_i;
    // Note-off wins when both strobes arrive together so a note can never hang.
    assign w_status = noteOffStrb_i ? {4'b1000, MIDI_CHANNEL} : {4'b1001, MIDI_CHANNEL};

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            r_state <= IDLE;
            r_note  <= 8'h00;
            r_vel   <= 8'h00;
            r_byte  <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
            r_lastStatus <= 8'h00;
`endif
        end else begin
            r_drop <= w_req && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_note  <= note_i & 8'h7F;
                        r_vel   <= noteOffStrb_i ? {1'b0, DEFAULT_OFF_VEL} : (vel_i & 8'h7F);
                        r_byte  <= w_status;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= STATUS;
`ifdef MIDI_RUNNING_STATUS_EN
                        if (w_status == r_lastStatus) begin
                            r_byte  <= note_i & 8'h7F;
                            r_state <= NOTE;
                        end
`endif
                    end
                end
                STATUS: begin
                    if (w_hs) begin
`ifdef MIDI_RUNNING_STATUS_EN
                        r_lastStatus <= r_byte;
`endif
                        r_byte  <= r_note;
                        r_state <= NOTE;
                    end
                end
                NOTE: begin
                    if (w_hs) begin
                        r_byte  <= r_vel;
                        r_state <= VEL;
                    end
                end
                VEL: begin
                    if (w_hs) begin
                        r_byte  <= 8'h00;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy_o          = r_busy;
    assign midiByte_o      = r_byte;
    assign midiByteValid_o = r_valid;
    assign dropStrb_o      = r_drop;

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: directed vector table, stall/running-status sequences, and random traffic
// against a byte-queue reference model.
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

module tb_midi_tx;

    localparam logic [7:0] CH     = 8'd3;
    localparam logic [7:0] OFFVEL = 8'd64;

    logic       clk_i = 1'b0;
    logic       nrst_i = 1'b0;
    logic       noteOnStrb_i = 1'b0;
    logic       noteOffStrb_i = 1'b0;
    logic [7:0] note_i = 8'h00;
    logic [7:0] vel_i = 8'h00;
    logic       busy_o;
    logic [7:0] midiByte_o;
    logic       midiByteValid_o;
    logic       midiByteReady_i = 1'b0;
    logic       dropStrb_o;

    midi_tx #(.MIDI_CHANNEL(4'd3), .DEFAULT_OFF_VEL(7'd64)) dut (
        .clk_i(clk_i),
        .nrst_i(nrst_i),
        .noteOnStrb_i(noteOnStrb_i),
        .noteOffStrb_i(noteOffStrb_i),
        .note_i(note_i),
        .vel_i(vel_i),
        .busy_o(busy_o),
        .midiByte_o(midiByte_o),
        .midiByteValid_o(midiByteValid_o),
        .midiByteReady_i(midiByteReady_i),
        .dropStrb_o(dropStrb_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes still to be sent for the message in flight.
    logic [7:0] modelQ[$];
    logic [7:0] modelLast = 8'h00;
    logic       modelDrop = 1'b0;
    logic [7:0] hsLog[$];

    typedef struct {
        logic       on;
        logic       off;
        logic [7:0] note;
        logic [7:0] vel;
        logic       rdy;
        logic       nrst;
        logic       expValid;
        logic       expBusy;
        logic [7:0] expByte;
        logic       expDrop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic on, logic off, logic [7:0] note, logic [7:0] vel, logic rdy, logic nrst,
                                logic eV, logic eB, logic [7:0] eByte, logic eD);
        vec_t v;
        v.on = on; v.off = off; v.note = note; v.vel = vel; v.rdy = rdy; v.nrst = nrst;
        v.expValid = eV; v.expBusy = eB; v.expByte = eByte; v.expDrop = eD;
        return v;
    endfunction

    task automatic checkEq(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep();
        logic [7:0] st;
        if (!nrst_i) begin
            modelQ.delete();
            modelDrop = 1'b0;
            modelLast = 8'h00;
        end else begin
            modelDrop = (modelQ.size() > 0) && (noteOnStrb_i || noteOffStrb_i);
            if (modelQ.size() > 0) begin
                if (midiByteReady_i) begin
                    if (modelQ[0][7]) modelLast = modelQ[0];
                    void'(modelQ.pop_front());
                end
            end else if (noteOnStrb_i || noteOffStrb_i) begin
                st = noteOffStrb_i ? (8'h80 | CH) : (8'h90 | CH);
`ifdef MIDI_RUNNING_STATUS_EN
                if (st != modelLast) modelQ.push_back(st);
`else
                modelQ.push_back(st);
`endif
                modelQ.push_back(note_i & 8'h7F);
                modelQ.push_back(noteOffStrb_i ? OFFVEL : (vel_i & 8'h7F));
            end
        end
    endtask

    task automatic checkOutput();
        checkEq("valid", {7'd0, midiByteValid_o}, {7'd0, modelQ.size() > 0});
        checkEq("busy", {7'd0, busy_o}, {7'd0, modelQ.size() > 0});
        checkEq("drop", {7'd0, dropStrb_o}, {7'd0, modelDrop});
        if (modelQ.size() > 0) checkEq("byte", midiByte_o, modelQ[0]);
        if (!nrst_i) checkEq("rstByte", midiByte_o, 8'h00);
    endtask

    task automatic cycle();
        logic       hsPre;
        logic [7:0] bytePre;
        hsPre   = nrst_i && midiByteValid_o && midiByteReady_i;
        bytePre = midiByte_o;
        @(posedge clk_i);
        if (hsPre) hsLog.push_back(bytePre);
        modelStep();
        #1;
        checkOutput();
        @(negedge clk_i);
    endtask

    task automatic applyStimulus(input logic on, input logic off, input logic [7:0] note, input logic [7:0] vel,
                                 input logic rdy, input logic nrst);
        noteOnStrb_i    = on;
        noteOffStrb_i   = off;
        note_i          = note;
        vel_i           = vel;
        midiByteReady_i = rdy;
        nrst_i          = nrst;
        cycle();
    endtask

    initial begin
        logic [7:0] exp3[3];
        logic [7:0] exp6[$];

        // Directed table; every message is preceded by reset so it holds with or without running status.
        // Test 1: note-on 0x3C/0x64, ready high.
        vecs.push_back(mk(0,0,8'h00,8'h00,1,0, 0,0,8'h00,0));
        vecs.push_back(mk(1,0,8'h3C,8'h64,1,1, 1,1,8'h93,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h3C,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h64,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 0,0,8'h00,0));
        // Test 2: note-off with note MSB set; vel_i ignored.
        vecs.push_back(mk(0,0,8'h00,8'h00,1,0, 0,0,8'h00,0));
        vecs.push_back(mk(0,1,8'hBC,8'h7F,1,1, 1,1,8'h83,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h3C,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h40,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 0,0,8'h00,0));
        // Test 4: both strobes -> off; strobe during NOTE dropped; strobe on final handshake dropped.
        vecs.push_back(mk(0,0,8'h00,8'h00,1,0, 0,0,8'h00,0));
        vecs.push_back(mk(1,1,8'h40,8'h11,1,1, 1,1,8'h83,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h40,0));
        vecs.push_back(mk(1,0,8'h55,8'h22,1,1, 1,1,8'h40,1));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 0,0,8'h00,0));
        vecs.push_back(mk(1,0,8'h01,8'h02,1,1, 1,1,8'h93,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h01,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h02,0));
        vecs.push_back(mk(1,0,8'h05,8'h06,1,1, 0,0,8'h00,1));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 0,0,8'h00,0));
        // Test 5: reset while the note byte is pending, then a fresh message.
        vecs.push_back(mk(0,0,8'h00,8'h00,1,0, 0,0,8'h00,0));
        vecs.push_back(mk(1,0,8'h22,8'h33,1,1, 1,1,8'h93,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,0,1, 1,1,8'h93,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h22,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,0,1, 1,1,8'h22,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,0,0, 0,0,8'h00,0));
        vecs.push_back(mk(1,0,8'h23,8'h01,1,1, 1,1,8'h93,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h23,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 1,1,8'h01,0));
        vecs.push_back(mk(0,0,8'h00,8'h00,1,1, 0,0,8'h00,0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].on, vecs[i].off, vecs[i].note, vecs[i].vel, vecs[i].rdy, vecs[i].nrst);
            checkEq("tblValid", {7'd0, midiByteValid_o}, {7'd0, vecs[i].expValid});
            checkEq("tblBusy", {7'd0, busy_o}, {7'd0, vecs[i].expBusy});
            checkEq("tblDrop", {7'd0, dropStrb_o}, {7'd0, vecs[i].expDrop});
            if (vecs[i].expValid || !vecs[i].nrst) checkEq("tblByte", midiByte_o, vecs[i].expByte);
        end

        // Test 3: five stall cycles on every byte of a note-on 0x45/0x7F.
        applyStimulus(0,0,8'h00,8'h00,0,0);
        hsLog.delete();
        exp3[0] = 8'h93; exp3[1] = 8'h45; exp3[2] = 8'h7F;
        applyStimulus(1,0,8'h45,8'h7F,0,1);
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 5; s++) begin
                applyStimulus(0,0,8'h00,8'h00,0,1);
                checkEq("stallByte", midiByte_o, exp3[b]);
                checkEq("stallValid", {7'd0, midiByteValid_o}, 8'd1);
            end
            applyStimulus(0,0,8'h00,8'h00,1,1);
        end
        applyStimulus(0,0,8'h00,8'h00,1,1);
        checkEq("stallHsCount", 8'(hsLog.size()), 8'd3);
        for (int b = 0; b < 3; b++)
            if (b < hsLog.size()) checkEq("stallHsByte", hsLog[b], exp3[b]);

        // Test 6: two note-ons then a note-off, ready high.
        applyStimulus(0,0,8'h00,8'h00,1,0);
        hsLog.delete();
        applyStimulus(1,0,8'h3C,8'h64,1,1);
        repeat (4) applyStimulus(0,0,8'h00,8'h00,1,1);
        applyStimulus(1,0,8'h40,8'h50,1,1);
        repeat (4) applyStimulus(0,0,8'h00,8'h00,1,1);
        applyStimulus(0,1,8'h3C,8'h11,1,1);
        repeat (4) applyStimulus(0,0,8'h00,8'h00,1,1);
`ifdef MIDI_RUNNING_STATUS_EN
        exp6 = '{8'h93, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h83, 8'h3C, 8'h40};
`else
        exp6 = '{8'h93, 8'h3C, 8'h64, 8'h93, 8'h40, 8'h50, 8'h83, 8'h3C, 8'h40};
`endif
        checkEq("seqCount", 8'(hsLog.size()), 8'(exp6.size()));
        for (int b = 0; b < exp6.size(); b++)
            if (b < hsLog.size()) checkEq("seqByte", hsLog[b], exp6[b]);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, 8'($urandom), 8'($urandom),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
        end

        noteOnStrb_i  = 1'b0;
        noteOffStrb_i = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- MIDI Channel Voice message encoder. It is the transmit-side counterpart of the MIDI note parser.
- Accepts note-on/note-off requests from synthesis or control logic. Serialises each request into a 3-byte MIDI message (status, note, velocity) for a fixed channel.
- Presents the bytes one at a time on a valid/ready byte interface feeding the UART transmitter.

Parameters:
- MIDI_CHANNEL, 0, channel nibble (0..15) placed in status byte bits [3:0].
- DEFAULT_OFF_VEL, 64, velocity byte sent with note-off messages (7-bit value).

Ports:
- clk_i  input  1  system clock
- nrst_i  input  1  reset; one clock; reset is synchronous and active-low
- noteOnStrb_i  input  1  single-cycle request: send note-on
- noteOffStrb_i  input  1  single-cycle request: send note-off
- note_i  input  `MIDI_PAYLOAD_BITS  note number; bit 7 ignored
- vel_i  input  `MIDI_PAYLOAD_BITS  note-on velocity; bit 7 ignored
- busy_o  output  1  high while a message is in flight; requests are ignored
- midiByte_o  output  8  byte to transmitter
- midiByteValid_o  output  1  midiByte_o holds a valid byte
- midiByteReady_i  input  1  transmitter accepts byte when valid && ready
- dropStrb_o  output  1  one-cycle pulse: a request arrived while busy and was discarded

Behaviour:
- All registers reset synchronously on a clk_i edge with nrst_i=0.
- Reset values: midiByte_o=0x00, midiByteValid_o=0, busy_o=0, dropStrb_o=0, FSM=IDLE.
- FSM states and transitions:
  - IDLE: waits for a request.
  - STATUS: presents the status byte.
  - NOTE: presents the note byte.
  - VEL: presents the velocity byte.
  - IDLE->STATUS on a request. STATUS->NOTE, NOTE->VEL, and VEL->IDLE each occur on a handshake (midiByteValid_o && midiByteReady_i at a clk_i edge).
- Request capture (IDLE only):
  - On a strobe at edge N, latch the command, note_i[6:0], and the velocity.
  - Velocity is vel_i[6:0] for on, DEFAULT_OFF_VEL[6:0] for off.
  - From edge N: busy_o=1, midiByteValid_o=1, midiByte_o = status byte.
  - Latency is 1 cycle from strobe to first valid byte.
- Byte values:
  - Status = {4'b1001, MIDI_CHANNEL[3:0]} for on, {4'b1000, MIDI_CHANNEL[3:0]} for off.
  - Note byte = {1'b0, note[6:0]}; velocity byte = {1'b0, vel[6:0]}. Data bytes always have MSB=0.
- Handshake rules:
  - While valid && !ready, midiByte_o and midiByteValid_o hold stable.
  - After a handshake, the next byte appears on the following cycle with valid still high. Back-to-back acceptance with ready held high gives 3 bytes in 3 consecutive cycles.
  - midiByteValid_o is never deasserted before its handshake.
- End of message: the handshake on the velocity byte returns the FSM to IDLE. At the next edge valid=0 and busy_o=0. A new request is accepted in the cycle after busy_o falls.
- Simultaneous events:
  - noteOnStrb_i and noteOffStrb_i high together in IDLE: note-off wins (safe default, avoids hung notes). No drop pulse.
  - Any strobe while busy_o=1, including the cycle of the final handshake: request discarded, dropStrb_o=1 for exactly one cycle.
- Reset mid-message: the message is abandoned. Valid drops at the reset edge and the partial message is not resumed. The downstream parser resynchronises on the next status byte.
- midiByteReady_i is ignored while valid=0.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined:
  - A lastStatus register (reset value 0x00 = none) records the last status byte sent.
  - If a new request's status equals lastStatus, STATUS is skipped. The note byte is presented at edge N and the message is 2 bytes.
  - lastStatus updates on the status-byte handshake and clears to 0x00 on reset.
- Undefined: every message carries its status byte (always 3 bytes). No lastStatus register exists.

Test Plan:
1. MIDI_CHANNEL=3, ready tied high; pulse noteOn with note_i=0x3C, vel_i=0x64 -> bytes 0x93, 0x3C, 0x64 on 3 consecutive cycles starting 1 cycle after the strobe; busy_o low the cycle after the last byte.
2. noteOff with note_i=0xBC (MSB set), DEFAULT_OFF_VEL=64 -> bytes 0x80, 0x3C, 0x40 with channel 0; vel_i ignored.
3. Ready low for 5 cycles on each byte of a note-on for 0x45/0x7F -> midiByte_o stable through each stall; each byte accepted exactly once; exactly 3 handshakes in total.
4. noteOn and noteOff in the same IDLE cycle (note 0x40) -> status 0x80 emitted; a second strobe during NOTE -> dropStrb_o pulses for 1 cycle and no extra message follows.
5. nrst_i=0 for one edge while valid with note byte pending -> valid=0, busy_o=0, midiByte_o=0x00 after that edge; the next request restarts with the status byte.
6. MIDI_RUNNING_STATUS_EN defined; two note-ons (0x3C/0x64, then 0x40/0x50) -> 0x90, 0x3C, 0x64, 0x40, 0x50. A following note-off for 0x3C -> 0x80, 0x3C, 0x40.
